// File: rtl/spi_fifo_seq.sv
// spi_fifo_seq: TX/RX byte FIFOs feeding an SPI controller via start/busy.
// Define SPI_FIFO_RX_EN to build the RX FIFO, rx_overflow and clear_flags.
module spi_fifo_seq #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_dc,
  input  logic       tx_end,
  input  logic       tx_rx,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       rx_overflow,
  input  logic       clear_flags,
  output logic       idle,
  output logic       spi_start,
  output logic [7:0] spi_data,
  output logic       spi_dc,
  output logic       spi_end_txn,
  input  logic       spi_busy,
  input  logic [7:0] spi_rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] CNT_ONE = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_e;

  state_e state_q, state_d;

  logic [10:0]           tx_mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] tx_wr_q, tx_rd_q;
  logic [DEPTH_LOG2:0]   tx_cnt_q, tx_cnt_d;
  logic                  tx_push, tx_pop;
  logic [10:0]           tx_head;

  logic       start_q, start_d;
  logic [7:0] data_q, data_d;
  logic       dc_q, dc_d;
  logic       end_q, end_d;
  logic       pend_q, pend_d;
  logic       rx_cap;

  assign tx_ready = tx_cnt_q != CNT_FULL;
  assign tx_push  = tx_valid && tx_ready;
  assign tx_head  = tx_mem_q[tx_rd_q];

  assign spi_start   = start_q;
  assign spi_data    = data_q;
  assign spi_dc      = dc_q;
  assign spi_end_txn = end_q;

  assign idle = (tx_cnt_q == '0) && (state_q == S_IDLE) && !spi_busy;

  always_comb begin
    tx_cnt_d = tx_cnt_q;
    if (tx_push && !tx_pop) begin
      tx_cnt_d = tx_cnt_q + CNT_ONE;
    end else if (!tx_push && tx_pop) begin
      tx_cnt_d = tx_cnt_q - CNT_ONE;
    end
  end

  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    data_d  = data_q;
    dc_d    = dc_q;
    end_d   = end_q;
    pend_d  = pend_q;
    tx_pop  = 1'b0;
    rx_cap  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if ((tx_cnt_q != '0) && !spi_busy) begin
          start_d = 1'b1;
          data_d  = tx_head[7:0];
          dc_d    = tx_head[8];
          end_d   = tx_head[9];
          pend_d  = tx_head[10];
          tx_pop  = 1'b1;
          state_d = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (spi_busy) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (!spi_busy) begin
          rx_cap  = pend_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      data_q   <= 8'h00;
      dc_q     <= 1'b0;
      end_q    <= 1'b0;
      pend_q   <= 1'b0;
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      data_q   <= data_d;
      dc_q     <= dc_d;
      end_q    <= end_d;
      pend_q   <= pend_d;
      tx_cnt_q <= tx_cnt_d;
      if (tx_push) begin
        tx_wr_q <= tx_wr_q + PTR_ONE;
      end
      if (tx_pop) begin
        tx_rd_q <= tx_rd_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem_q[tx_wr_q] <= {tx_rx, tx_end, tx_dc, tx_data};
    end
  end

`ifdef SPI_FIFO_RX_EN
  logic [7:0]            rx_mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] rx_wr_q, rx_rd_q;
  logic [DEPTH_LOG2:0]   rx_cnt_q, rx_cnt_d;
  logic                  rx_full, rx_push, rx_pop, rx_drop;
  logic                  ovf_q, ovf_d;

  assign rx_valid    = rx_cnt_q != '0;
  assign rx_data     = rx_valid ? rx_mem_q[rx_rd_q] : 8'h00;
  assign rx_overflow = ovf_q;

  assign rx_full = rx_cnt_q == CNT_FULL;
  assign rx_pop  = rx_ready && rx_valid;
  // A full FIFO still accepts a capture when the head leaves on the same edge.
  assign rx_push = rx_cap && (!rx_full || rx_pop);
  assign rx_drop = rx_cap && rx_full && !rx_pop;

  always_comb begin
    rx_cnt_d = rx_cnt_q;
    if (rx_push && !rx_pop) begin
      rx_cnt_d = rx_cnt_q + CNT_ONE;
    end else if (!rx_push && rx_pop) begin
      rx_cnt_d = rx_cnt_q - CNT_ONE;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (rx_drop) begin
      ovf_d = 1'b1;
    end else if (clear_flags) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rx_cnt_q <= rx_cnt_d;
      ovf_q    <= ovf_d;
      if (rx_push) begin
        rx_wr_q <= rx_wr_q + PTR_ONE;
      end
      if (rx_pop) begin
        rx_rd_q <= rx_rd_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) begin
      rx_mem_q[rx_wr_q] <= spi_rdata;
    end
  end
`else
  logic unused_rx;
  assign unused_rx = ^{rx_cap, pend_q, rx_ready, clear_flags, spi_rdata};

  assign rx_valid    = 1'b0;
  assign rx_data     = 8'h00;
  assign rx_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_spi_fifo_seq.sv
// tb_spi_fifo_seq: queue-based reference model plus a simple SPI controller
// responder; directed scenarios followed by randomized traffic.
module tb_spi_fifo_seq;

  localparam int DL2   = 2;
  localparam int DEPTH = 1 << DL2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, tx_valid, tx_dc, tx_end, tx_rx;
  logic       rx_ready, clear_flags, spi_busy;
  logic [7:0] tx_data, spi_rdata;
  logic       tx_ready, rx_valid, rx_overflow, idle;
  logic       spi_start, spi_dc, spi_end_txn;
  logic [7:0] rx_data, spi_data;

  spi_fifo_seq #(.DEPTH_LOG2(DL2)) dut (
    .clk(clk),
    .rst(rst),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_dc(tx_dc),
    .tx_end(tx_end),
    .tx_rx(tx_rx),
    .tx_ready(tx_ready),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .rx_ready(rx_ready),
    .rx_overflow(rx_overflow),
    .clear_flags(clear_flags),
    .idle(idle),
    .spi_start(spi_start),
    .spi_data(spi_data),
    .spi_dc(spi_dc),
    .spi_end_txn(spi_end_txn),
    .spi_busy(spi_busy),
    .spi_rdata(spi_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // reference model: queued bytes, the byte on the wire, captured bytes
  logic [10:0] m_txq[$];
  logic [7:0]  m_rxq[$];
  bit          m_inflight, m_seen_busy, m_pend_rx, m_ovf, m_start;
  logic [7:0]  m_data;
  bit          m_dc, m_end;

  // controller responder
  bit         env_pend;
  int         env_left, env_len, force_len, rd_mode, busy_fall_cyc, nstarts;
  bit         gap_on;
  logic [7:0] rd_val;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
  endtask

  task automatic model_step();
    bit acc, issue, done;
    logic [10:0] e;
    if (rst) begin
      m_txq.delete();
      m_rxq.delete();
      m_inflight = 0; m_seen_busy = 0; m_pend_rx = 0;
      m_ovf = 0; m_start = 0; m_data = 8'h00; m_dc = 0; m_end = 0;
      return;
    end
    acc   = tx_valid && (m_txq.size() < DEPTH);
    issue = !m_inflight && (m_txq.size() != 0) && !spi_busy;
    done  = m_inflight && m_seen_busy && !spi_busy;
`ifdef SPI_FIFO_RX_EN
    if (rx_ready && m_rxq.size() != 0) void'(m_rxq.pop_front());
    if (clear_flags) m_ovf = 0;
    if (done && m_pend_rx) begin
      if (m_rxq.size() < DEPTH) m_rxq.push_back(spi_rdata);
      else m_ovf = 1;
    end
`endif
    m_start = issue;
    if (issue) begin
      e = m_txq.pop_front();
      m_data = e[7:0]; m_dc = e[8]; m_end = e[9]; m_pend_rx = e[10];
      m_inflight = 1; m_seen_busy = 0;
    end else if (done) begin
      m_inflight = 0;
    end else if (m_inflight && spi_busy) begin
      m_seen_busy = 1;
    end
    if (acc) m_txq.push_back({tx_rx, tx_end, tx_dc, tx_data});
  endtask

  task automatic compare_all();
    chk("spi_start", spi_start, m_start);
    chk("spi_data", spi_data, m_data);
    chk("spi_dc", spi_dc, m_dc);
    chk("spi_end_txn", spi_end_txn, m_end);
    chk("tx_ready", tx_ready, m_txq.size() < DEPTH);
    chk("rx_valid", rx_valid, m_rxq.size() != 0);
    chk("rx_data", rx_data, m_rxq.size() != 0 ? m_rxq[0] : 8'h00);
    chk("rx_overflow", rx_overflow, m_ovf);
    chk("idle", idle, m_txq.size() == 0 && !m_inflight && !spi_busy);
  endtask

  task automatic env_update();
    if (rst) begin
      spi_busy = 0; env_pend = 0; env_left = 0;
      return;
    end
    if (env_pend) begin
      spi_busy = 1; env_left = env_len; env_pend = 0;
    end else if (spi_busy) begin
      env_left--;
      if (env_left <= 0) begin
        spi_busy = 0;
        busy_fall_cyc = cyc;
        if (rd_mode == 0) spi_rdata = 8'($urandom);
        else spi_rdata = rd_val;
        if (rd_mode == 2) rd_val = rd_val + 8'h11;
      end
    end
    if (spi_start) begin
      env_pend = 1;
      env_len = force_len > 0 ? force_len : int'($urandom_range(1, 4));
      if (gap_on) begin
        nstarts++;
        if (busy_fall_cyc >= 0) chk("start_gap", cyc - busy_fall_cyc, 2);
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(negedge clk);
    cyc++;
    compare_all();
    env_update();
  endtask

  task automatic do_reset();
    rst = 1; spi_busy = 0; env_pend = 0; env_left = 0;
    tx_valid = 0; rx_ready = 0; clear_flags = 0;
    cycle();
    rst = 0;
  endtask

  task automatic push(logic [7:0] d, bit dc, bit en, bit rx);
    tx_valid = 1; tx_data = d; tx_dc = dc; tx_end = en; tx_rx = rx;
    cycle();
    tx_valid = 0;
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while (!(m_txq.size() == 0 && !m_inflight && !spi_busy && !env_pend)) begin
      if (n >= budget) begin timeout("wait_idle"); return; end
      cycle(); n++;
    end
  endtask

  task automatic wait_busy_fall(int budget);
    bit seen = spi_busy;
    for (int n = 0; n < budget; n++) begin
      cycle();
      if (spi_busy) seen = 1;
      else if (seen) return;
    end
    timeout("wait_busy_fall");
  endtask

  task automatic wait_busy_high(int budget);
    for (int n = 0; n < budget; n++) begin
      if (spi_busy) return;
      cycle();
    end
    timeout("wait_busy_high");
  endtask

  logic [7:0] exp_rx [4];

  initial begin
    rst = 1; tx_valid = 0; tx_data = 0; tx_dc = 0; tx_end = 0; tx_rx = 0;
    rx_ready = 0; clear_flags = 0; spi_busy = 0; spi_rdata = 0;
    env_pend = 0; env_left = 0; env_len = 1; force_len = 0;
    rd_mode = 0; rd_val = 0; busy_fall_cyc = -1; gap_on = 0; nstarts = 0;

    // reset values
    do_reset();
    chk("rst_spi_data", spi_data, 8'h00);
    chk("rst_idle", idle, 1);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_ovf", rx_overflow, 0);

    // single byte
    push(8'hA5, 1, 1, 0);
    cycle();
    chk("single_start", spi_start, 1);
    chk("single_data", spi_data, 8'hA5);
    chk("single_dc", spi_dc, 1);
    chk("single_end", spi_end_txn, 1);
    wait_idle(50);
    chk("single_no_rx", rx_valid, 0);

    // back-to-back with a full TX FIFO
    force_len = 12;
    push(8'h10, 0, 0, 0);
    cycle();
    gap_on = 1; busy_fall_cyc = -1; nstarts = 0;
    wait_busy_high(10);
    push(8'hB0, 1, 0, 0);
    push(8'hB1, 0, 1, 0);
    push(8'hB2, 1, 1, 0);
    push(8'hB3, 0, 0, 0);
    chk("b2b_full", tx_ready, 0);
    force_len = 0;
    push(8'hEE, 1, 1, 0);
    wait_idle(100);
    chk("b2b_starts", nstarts, 4);
    gap_on = 0;

    // capture path
    rd_mode = 1; rd_val = 8'h3C;
    push(8'h00, 0, 1, 1);
    wait_busy_fall(50);
    cycle();
`ifdef SPI_FIFO_RX_EN
    chk("cap_valid", rx_valid, 1);
    chk("cap_data", rx_data, 8'h3C);
`else
    chk("cap_valid_off", rx_valid, 0);
`endif
    rx_ready = 1;
    cycle();
    rx_ready = 0;
    chk("cap_popped", rx_valid, 0);
    wait_idle(50);

    // overflow: five captures, no pops
    rd_mode = 2; rd_val = 8'h11;
    for (int i = 0; i < 5; i++) begin
      push(8'(i), 0, 0, 1);
      wait_idle(50);
    end
`ifdef SPI_FIFO_RX_EN
    chk("ovf_set", rx_overflow, 1);
    chk("ovf_head", rx_data, 8'h11);
`endif
    clear_flags = 1;
    cycle();
    clear_flags = 0;
    chk("ovf_clr", rx_overflow, 0);

    // full RX with pop on the capture edge
    push(8'h77, 0, 0, 1);
    wait_busy_fall(50);
    rx_ready = 1;
    cycle();
    rx_ready = 0;
    chk("simul_ovf", rx_overflow, 0);
`ifdef SPI_FIFO_RX_EN
    exp_rx[0] = 8'h22; exp_rx[1] = 8'h33; exp_rx[2] = 8'h44; exp_rx[3] = 8'h66;
    for (int i = 0; i < 4; i++) begin
      chk("simul_drain", rx_data, exp_rx[i]);
      rx_ready = 1;
      cycle();
      rx_ready = 0;
    end
    chk("simul_empty", rx_valid, 0);
`endif
    wait_idle(50);

    // randomized traffic
    rd_mode = 0;
    for (int i = 0; i < 400; i++) begin
      tx_valid    = ($urandom_range(0, 1) == 1);
      tx_data     = 8'($urandom);
      tx_dc       = 1'($urandom);
      tx_end      = 1'($urandom);
      tx_rx       = 1'($urandom);
      rx_ready    = ($urandom_range(0, 9) < 3);
      clear_flags = ($urandom_range(0, 19) == 0);
      cycle();
    end
    tx_valid = 0; rx_ready = 0; clear_flags = 0;
    wait_idle(100);

    // reset while waiting for busy to fall with 3 bytes queued
    force_len = 15;
    push(8'hC0, 0, 0, 1);
    push(8'hC1, 0, 0, 0);
    push(8'hC2, 0, 0, 0);
    push(8'hC3, 0, 0, 0);
    for (int n = 0; n < 20 && !m_seen_busy; n++) cycle();
    chk("rst_mid_waitdone", m_seen_busy, 1);
    force_len = 0;
    do_reset();
    chk("rst_mid_idle", idle, 1);
    chk("rst_mid_tx_ready", tx_ready, 1);
    chk("rst_mid_start", spi_start, 0);
    chk("rst_mid_rx_valid", rx_valid, 0);
    for (int i = 0; i < 5; i++) cycle();
    chk("rst_mid_quiet", spi_start, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
